mux_demux16_4: RTL and testbench

MUX_DEMUX16_4 -- requirements
Module: demux16_4

---
 rtl/demux_pkg.sv | 26 ++
 rtl/demux_scan_ctr.sv | 31 +++
 rtl/mux_demux16_4.sv | 98 +++++++++
 tb/tb_mux_demux16_4.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and types for the 16-bit serial demultiplexer.
// Holds the data/select widths, the mode encoding and the scan FSM state type.
package demux_pkg;

  localparam int DATA_W = 16;
  localparam int SEL_W  = 4;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

  localparam logic [SEL_W-1:0] CNT_LAST = SEL_W'(DATA_W - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // One-hot bit mask selecting word bit idx.
  function automatic logic [DATA_W-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [DATA_W-1:0] mask;
    mask      = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/demux_scan_ctr.sv
// Scan index counter for mux_demux16_4: tracks the next scan bit position
// and flags the capture that completes a 16-bit frame.
module demux_scan_ctr
  import demux_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             mode,
  input  logic             advance,
  output logic [SEL_W-1:0] cnt,
  output logic             wrap
);

  logic [SEL_W-1:0] r_cnt;

  // Addressed mode pins the index at 0 so every scan frame starts from bit 0.
  // NOTE: state registers are written with non-blocking assignments so all
  // flops sample the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clear || (mode == MODE_ADDR)) begin
      r_cnt <= '0;
    end else if (advance) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt  = r_cnt;
  assign wrap = advance && (r_cnt == CNT_LAST);

endmodule

// File: rtl/mux_demux16_4.sv
// 1-to-16 registered serial demultiplexer with addressed and scan modes.
// Optional macro DEMUX16_STROBE_EN adds a one-hot write strobe output.
module mux_demux16_4
  import demux_pkg::*;
#(
  parameter logic [DATA_W-1:0] INIT = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  input  logic [SEL_W-1:0]  s,
  input  logic              in_valid,
  input  logic              mode,
  input  logic              clear,
  output logic [DATA_W-1:0] out,
  output logic [SEL_W-1:0]  cnt,
  output logic              frame_done
`ifdef DEMUX16_STROBE_EN
  ,
  output logic [DATA_W-1:0] strobe
`endif
);

  logic [DATA_W-1:0] r_out;
  logic              r_frame_done;
  state_t            r_state;

  logic              w_advance;
  logic              w_wrap;
  logic [SEL_W-1:0]  w_cnt;
  logic [SEL_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_mask;

  // Clear outranks in_valid, so a colliding data bit never advances the scan.
  assign w_advance = in_valid && (mode == MODE_SCAN) && !clear;
  assign w_idx     = (mode == MODE_SCAN) ? w_cnt : s;
  assign w_mask    = onehot(w_idx);

  demux_scan_ctr u_scan_ctr (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .mode    (mode),
    .advance (w_advance),
    .cnt     (w_cnt),
    .wrap    (w_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_out <= INIT;
    end else if (in_valid) begin
      r_out <= (r_out & ~w_mask) | ({DATA_W{in}} & w_mask);
    end
  end

  // frame_done is a registered FSM output, so it pulses the cycle after the
  // capture at index 15 and is dropped for frames aborted by clear or mode.
  always_ff @(posedge clk) begin
    if (rst || clear || (mode == MODE_ADDR)) begin
      r_state      <= ST_IDLE;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_advance) r_state <= ST_SCAN;
        end
        ST_SCAN: begin
          if (w_wrap) begin
            r_state      <= ST_IDLE;
            r_frame_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef DEMUX16_STROBE_EN
  logic [DATA_W-1:0] r_strobe;

  always_ff @(posedge clk) begin
    if (rst || clear || !in_valid) begin
      r_strobe <= '0;
    end else begin
      r_strobe <= w_mask;
    end
  end

  assign strobe = r_strobe;
`endif

  assign out        = r_out;
  assign cnt        = w_cnt;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_mux_demux16_4.sv
// Directed testbench for mux_demux16_4: one instance with default INIT and one
// with INIT=16'h00FF share stimulus. Define DEMUX16_STROBE_EN to cover strobe.
module tb_mux_demux16_4;

  logic        clk;
  logic        rst;
  logic        in;
  logic [3:0]  s;
  logic        in_valid;
  logic        mode;
  logic        clear;

  logic [15:0] out_a;
  logic [3:0]  cnt_a;
  logic        fd_a;
  logic [15:0] out_b;
  logic [3:0]  cnt_b;
  logic        fd_b;
`ifdef DEMUX16_STROBE_EN
  logic [15:0] strobe_a;
  logic [15:0] strobe_b;
`endif

  int checks   = 0;
  int failures = 0;

  mux_demux16_4 dut_a (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .s          (s),
    .in_valid   (in_valid),
    .mode       (mode),
    .clear      (clear),
    .out        (out_a),
    .cnt        (cnt_a),
    .frame_done (fd_a)
`ifdef DEMUX16_STROBE_EN
    ,
    .strobe     (strobe_a)
`endif
  );

  mux_demux16_4 #(.INIT(16'h00FF)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .s          (s),
    .in_valid   (in_valid),
    .mode       (mode),
    .clear      (clear),
    .out        (out_b),
    .cnt        (cnt_b),
    .frame_done (fd_b)
`ifdef DEMUX16_STROBE_EN
    ,
    .strobe     (strobe_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in = 1'b0; s = 4'd0; in_valid = 1'b0; mode = 1'b0; clear = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (out_a !== 16'h0000) begin failures++; $display("FAIL reset_out_a got=%h exp=%h", out_a, 16'h0000); end
    checks++; if (out_b !== 16'h00FF) begin failures++; $display("FAIL reset_out_b got=%h exp=%h", out_b, 16'h00FF); end
    checks++; if (cnt_a !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt_a); end
    checks++; if (fd_a !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", fd_a); end
  endtask

  task automatic test_addressed();
    mode = 1'b0; s = 4'd5; in = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_a !== 16'h0020) begin failures++; $display("FAIL addr_set_a got=%h exp=%h", out_a, 16'h0020); end
    checks++; if (out_b !== 16'h00FF) begin failures++; $display("FAIL addr_set_b got=%h exp=%h", out_b, 16'h00FF); end
    checks++; if (cnt_a !== 4'd0 || fd_a !== 1'b0) begin failures++; $display("FAIL addr_cnt_fd got=%0d/%b exp=0/0", cnt_a, fd_a); end
    s = 4'd5; in = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_a !== 16'h0000) begin failures++; $display("FAIL addr_clr_a got=%h exp=%h", out_a, 16'h0000); end
    checks++; if (out_b !== 16'h00DF) begin failures++; $display("FAIL addr_clr_b got=%h exp=%h", out_b, 16'h00DF); end
    // in_valid low: nothing may be written even with a live bit and select.
    s = 4'd3; in = 1'b1;
    tick();
    checks++; if (out_a !== 16'h0000) begin failures++; $display("FAIL addr_hold_a got=%h exp=%h", out_a, 16'h0000); end
    checks++; if (out_b !== 16'h00DF) begin failures++; $display("FAIL addr_hold_b got=%h exp=%h", out_b, 16'h00DF); end
  endtask

  task automatic test_scan_frame();
    logic [15:0] pat;
    logic [3:0]  exp_cnt;
    pat = 16'hA5C3;
    mode = 1'b1; s = 4'd0;
    for (int i = 0; i < 16; i++) begin
      in = pat[i]; in_valid = 1'b1;
      tick();
      exp_cnt = 4'(i + 1);
      checks++; if (cnt_a !== exp_cnt) begin failures++; $display("FAIL scan_cnt[%0d] got=%0d exp=%0d", i, cnt_a, exp_cnt); end
      checks++; if (fd_a !== (i == 15)) begin failures++; $display("FAIL scan_fd[%0d] got=%b exp=%b", i, fd_a, (i == 15)); end
    end
    in_valid = 1'b0;
    checks++; if (out_a !== 16'hA5C3) begin failures++; $display("FAIL scan_out_a got=%h exp=%h", out_a, 16'hA5C3); end
    checks++; if (out_b !== 16'hA5C3) begin failures++; $display("FAIL scan_out_b got=%h exp=%h", out_b, 16'hA5C3); end
    tick();
    checks++; if (fd_a !== 1'b0) begin failures++; $display("FAIL scan_fd_single got=%b exp=0", fd_a); end
    checks++; if (out_a !== 16'hA5C3 || cnt_a !== 4'd0) begin failures++; $display("FAIL scan_idle_hold got=%h/%0d exp=a5c3/0", out_a, cnt_a); end
  endtask

  task automatic test_clear_collision();
    mode = 1'b1; in = 1'b1; in_valid = 1'b1;
    repeat (3) tick();
    checks++; if (cnt_a !== 4'd3) begin failures++; $display("FAIL clr_pre_cnt got=%0d exp=3", cnt_a); end
    clear = 1'b1;
    tick();
    checks++; if (out_a !== 16'h0000) begin failures++; $display("FAIL clr_out_a got=%h exp=%h", out_a, 16'h0000); end
    checks++; if (out_b !== 16'h00FF) begin failures++; $display("FAIL clr_out_b got=%h exp=%h", out_b, 16'h00FF); end
    checks++; if (cnt_a !== 4'd0 || cnt_b !== 4'd0) begin failures++; $display("FAIL clr_cnt got=%0d/%0d exp=0/0", cnt_a, cnt_b); end
    checks++; if (fd_a !== 1'b0) begin failures++; $display("FAIL clr_fd got=%b exp=0", fd_a); end
    mode = 1'b0; s = 4'd8;
    tick();
    checks++; if (out_b !== 16'h00FF) begin failures++; $display("FAIL clr_addr_b got=%h exp=%h", out_b, 16'h00FF); end
    clear = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_aborted_frame();
    mode = 1'b1; in = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (fd_a !== 1'b0) begin failures++; $display("FAIL abort_part_fd[%0d] got=%b exp=0", i, fd_a); end
    end
    checks++; if (cnt_a !== 4'd7) begin failures++; $display("FAIL abort_part_cnt got=%0d exp=7", cnt_a); end
    mode = 1'b0; in_valid = 1'b0;
    tick();
    checks++; if (cnt_a !== 4'd0 || fd_a !== 1'b0) begin failures++; $display("FAIL abort_mode_cnt got=%0d/%b exp=0/0", cnt_a, fd_a); end
    mode = 1'b1; in = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++; if (fd_a !== (i == 15)) begin failures++; $display("FAIL abort_full_fd[%0d] got=%b exp=%b", i, fd_a, (i == 15)); end
    end
    in_valid = 1'b0;
    checks++; if (out_a !== 16'h0000 || out_b !== 16'h0000) begin failures++; $display("FAIL abort_out got=%h/%h exp=0000/0000", out_a, out_b); end
    tick();
    checks++; if (fd_a !== 1'b0) begin failures++; $display("FAIL abort_fd_drop got=%b exp=0", fd_a); end
  endtask

  task automatic test_reset_midframe();
    mode = 1'b1; in = 1'b1; in_valid = 1'b1;
    repeat (10) tick();
    checks++; if (out_a !== 16'h03FF || cnt_a !== 4'd10) begin failures++; $display("FAIL rstmid_pre got=%h/%0d exp=03ff/10", out_a, cnt_a); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_a !== 16'h0000) begin failures++; $display("FAIL rstmid_out_a got=%h exp=%h", out_a, 16'h0000); end
    checks++; if (out_b !== 16'h00FF) begin failures++; $display("FAIL rstmid_out_b got=%h exp=%h", out_b, 16'h00FF); end
    checks++; if (cnt_a !== 4'd0 || fd_a !== 1'b0) begin failures++; $display("FAIL rstmid_cnt got=%0d/%b exp=0/0", cnt_a, fd_a); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_a !== 16'h0001) begin failures++; $display("FAIL rstmid_first got=%h exp=%h", out_a, 16'h0001); end
    checks++; if (cnt_a !== 4'd1) begin failures++; $display("FAIL rstmid_cnt1 got=%0d exp=1", cnt_a); end
  endtask

`ifdef DEMUX16_STROBE_EN
  task automatic test_strobe();
    mode = 1'b0; s = 4'd15; in = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (strobe_a !== 16'h8000) begin failures++; $display("FAIL strobe_set got=%h exp=%h", strobe_a, 16'h8000); end
    checks++; if (out_a !== 16'h8001) begin failures++; $display("FAIL strobe_out got=%h exp=%h", out_a, 16'h8001); end
    tick();
    checks++; if (strobe_a !== 16'h0000) begin failures++; $display("FAIL strobe_drop got=%h exp=%h", strobe_a, 16'h0000); end
  endtask
`endif

  initial begin
    test_reset();
    test_addressed();
    test_scan_frame();
    test_clear_collision();
    test_aborted_frame();
    test_reset_midframe();
`ifdef DEMUX16_STROBE_EN
    test_strobe();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
